// File: rtl/pipe_decoder.sv
// pipe_decoder: registered decode stage with valid/ready handshake, load-use bubbles and a stall counter
module pipe_decoder #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int EXT_ISA = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_wr_reg,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_wr_reg,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_jtarget,
  output logic [DATA_W-1:0] out_pc,
  output logic              out_alu_src,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_branch_ne,
  output logic              out_jmp,
  output logic              out_jr,
  output logic              out_pc_to_ra,
  output logic [2:0]        out_alu_op,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_SLT = 3'd3, ALU_AND = 3'd4;
  localparam bit EXT = EXT_ISA != 0;
  typedef struct packed {
    logic [REG_AW-1:0] rs, rt, wr_reg;
    logic [DATA_W-1:0] imm, jtarget, pc;
    logic alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic branch, branch_ne, jmp, jr, pc_to_ra;
    logic [2:0] alu_op;
    logic illegal;
  } bundle_t;
  bundle_t dec, q;
  logic [5:0] op, func;
  logic [REG_AW-1:0] rs, rt, rd, dst;
  logic [DATA_W-1:0] sext, zext;
  logic uses_rt, hazard, adv;
  assign op   = in_instr[31:26];
  assign func = in_instr[5:0];
  assign rs   = REG_AW'(in_instr[25:21]);
  assign rt   = REG_AW'(in_instr[20:16]);
  assign rd   = REG_AW'(in_instr[15:11]);
  assign sext = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
  assign zext = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
  assign uses_rt  = op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2b;
  assign hazard   = in_valid && ex_mem_read && ex_wr_reg != '0 && (ex_wr_reg == rs || (uses_rt && ex_wr_reg == rt));
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !hazard && !flush;
  always_comb begin
    dec = '0;
    dst = rt;
    dec.rs = rs;
    dec.rt = rt;
    dec.pc = in_pc;
    dec.imm = sext;
    dec.jtarget = {in_pc[DATA_W-1:28], in_instr[25:0], 2'b00};
    case (op)
      6'h00: begin
        dst = rd;
        case (func)
          6'h20: begin dec.reg_write = 1'b1; dec.alu_op = ALU_ADD; end
          6'h22: begin dec.reg_write = 1'b1; dec.alu_op = ALU_SUB; end
          6'h24: if (EXT) begin dec.reg_write = 1'b1; dec.alu_op = ALU_AND; end else dec.illegal = 1'b1;
          6'h25: if (EXT) begin dec.reg_write = 1'b1; dec.alu_op = ALU_OR; end else dec.illegal = 1'b1;
          6'h2a: if (EXT) begin dec.reg_write = 1'b1; dec.alu_op = ALU_SLT; end else dec.illegal = 1'b1;
          6'h08: if (EXT) begin dec.jr = 1'b1; dec.jmp = 1'b1; end else dec.illegal = 1'b1;
          default: dec.illegal = 1'b1;
        endcase
      end
      6'h02: dec.jmp = 1'b1;
      6'h03: begin dec.jmp = 1'b1; dec.reg_write = 1'b1; dec.pc_to_ra = 1'b1; dst = REG_AW'(31); end
      6'h04: begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; end
      6'h05: if (EXT) begin dec.branch = 1'b1; dec.branch_ne = 1'b1; dec.alu_op = ALU_SUB; end else dec.illegal = 1'b1;
      6'h08: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_ADD; end
      6'h0a: if (EXT) begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_SLT; end else dec.illegal = 1'b1;
      6'h0c: if (EXT) begin dec.imm = zext; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_AND; end else dec.illegal = 1'b1;
      6'h0d: if (EXT) begin dec.imm = zext; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_OR; end else dec.illegal = 1'b1;
      6'h23: begin dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1; end
      6'h2b: begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
    dec.wr_reg = dec.reg_write ? dst : '0;
  end
  // flush outranks a hazard so a squashed load-use pair is not counted as a stall
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      q <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      q <= '0;
    end else if (adv && hazard) begin
      out_valid <= 1'b0;
      q <= '0;
      stall_cnt <= &stall_cnt ? stall_cnt : stall_cnt + CNT_W'(1);
    end else if (adv) begin
      out_valid <= in_valid;
      q <= in_valid ? dec : '0;
    end
  assign out_rs         = q.rs;
  assign out_rt         = q.rt;
  assign out_wr_reg     = q.wr_reg;
  assign out_imm        = q.imm;
  assign out_jtarget    = q.jtarget;
  assign out_pc         = q.pc;
  assign out_alu_src    = q.alu_src;
  assign out_mem_to_reg = q.mem_to_reg;
  assign out_reg_write  = q.reg_write;
  assign out_mem_read   = q.mem_read;
  assign out_mem_write  = q.mem_write;
  assign out_branch     = q.branch;
  assign out_branch_ne  = q.branch_ne;
  assign out_jmp        = q.jmp;
  assign out_jr         = q.jr;
  assign out_pc_to_ra   = q.pc_to_ra;
  assign out_alu_op     = q.alu_op;
  assign out_illegal    = q.illegal;
endmodule

// File: tb/tb_pipe_decoder.sv
// tb_pipe_decoder: directed checks of a full-ISA decoder and a base-ISA decoder with a 2-bit stall counter
module tb_pipe_decoder;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, ex_mem_read = 0, out_ready = 1;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic [4:0] ex_wr_reg = 0;
  logic in_ready, out_valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic branch, branch_ne, jmp, jr, pc_to_ra, illegal;
  logic [4:0] rs, rt, wr_reg;
  logic [31:0] imm, jtarget, pc;
  logic [2:0] alu_op;
  logic [15:0] stall_cnt;
  logic d0_in_ready, d0_out_valid, d0_alu_src, d0_mem_to_reg, d0_reg_write, d0_mem_read, d0_mem_write;
  logic d0_branch, d0_branch_ne, d0_jmp, d0_jr, d0_pc_to_ra, d0_illegal;
  logic [4:0] d0_rs, d0_rt, d0_wr_reg;
  logic [31:0] d0_imm, d0_jtarget, d0_pc;
  logic [2:0] d0_alu_op;
  logic [1:0] d0_stall_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_wr_reg(ex_wr_reg), .out_ready(out_ready),
    .out_valid(out_valid), .out_rs(rs), .out_rt(rt), .out_wr_reg(wr_reg), .out_imm(imm),
    .out_jtarget(jtarget), .out_pc(pc), .out_alu_src(alu_src), .out_mem_to_reg(mem_to_reg),
    .out_reg_write(reg_write), .out_mem_read(mem_read), .out_mem_write(mem_write), .out_branch(branch),
    .out_branch_ne(branch_ne), .out_jmp(jmp), .out_jr(jr), .out_pc_to_ra(pc_to_ra), .out_alu_op(alu_op),
    .out_illegal(illegal), .stall_cnt(stall_cnt));
  pipe_decoder #(.EXT_ISA(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_wr_reg(ex_wr_reg), .out_ready(out_ready),
    .out_valid(d0_out_valid), .out_rs(d0_rs), .out_rt(d0_rt), .out_wr_reg(d0_wr_reg), .out_imm(d0_imm),
    .out_jtarget(d0_jtarget), .out_pc(d0_pc), .out_alu_src(d0_alu_src), .out_mem_to_reg(d0_mem_to_reg),
    .out_reg_write(d0_reg_write), .out_mem_read(d0_mem_read), .out_mem_write(d0_mem_write),
    .out_branch(d0_branch), .out_branch_ne(d0_branch_ne), .out_jmp(d0_jmp), .out_jr(d0_jr),
    .out_pc_to_ra(d0_pc_to_ra), .out_alu_op(d0_alu_op), .out_illegal(d0_illegal), .stall_cnt(d0_stall_cnt));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    in_valid = 1;
    in_instr = 32'h00221820;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_wr_reg", wr_reg, 0);
    chk("rst_imm", imm, 0);
    chk("rst_reg_write", reg_write, 0);
    rst = 0;
    in_pc = 32'h4;
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_wr_reg", wr_reg, 3);
    chk("add_reg_write", reg_write, 1);
    chk("add_alu_op", alu_op, 0);
    chk("add_rs_rt", {rs, rt}, {5'd1, 5'd2});
    in_instr = 32'h8C25FFFC;
    tick();
    chk("lw_imm", imm, 32'hFFFFFFFC);
    chk("lw_wr_reg", wr_reg, 5);
    chk("lw_ctrl", {mem_read, mem_to_reg, alu_src, reg_write, mem_write}, 5'b11110);
    ex_mem_read = 1;
    ex_wr_reg = 5;
    in_instr = 32'h00A23020;
    #1;
    chk("hz_in_ready", in_ready, 0);
    tick();
    chk("hz_bubble", out_valid, 0);
    chk("hz_bubble_wr", wr_reg, 0);
    chk("hz_stall", stall_cnt, 1);
    chk("hz_stall_d0", d0_stall_cnt, 1);
    ex_mem_read = 0;
    #1;
    chk("hz_clear_ready", in_ready, 1);
    tick();
    chk("hz_issue_valid", out_valid, 1);
    chk("hz_issue_wr", wr_reg, 6);
    chk("hz_issue_rs", rs, 5);
    out_ready = 0;
    in_instr = 32'h00223822;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", in_ready, 0);
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_wr", {wr_reg, alu_op}, {5'd6, 3'd0});
    end
    out_ready = 1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    tick();
    chk("sub_wr", wr_reg, 7);
    chk("sub_alu_op", alu_op, 1);
    flush = 1;
    in_instr = 32'h0C000100;
    in_pc = 32'h40000004;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_valid", out_valid, 0);
    flush = 0;
    tick();
    chk("jal_valid", out_valid, 1);
    chk("jal_wr", wr_reg, 31);
    chk("jal_ctrl", {pc_to_ra, jmp, reg_write, jr}, 4'b1110);
    chk("jal_jtarget", jtarget, 32'h40000400);
    chk("jal_pc", pc, 32'h40000004);
    in_instr = 32'h34028000;
    tick();
    chk("ori_imm", imm, 32'h00008000);
    chk("ori_wr", wr_reg, 2);
    chk("ori_alu", {alu_op, alu_src, illegal}, {3'd2, 1'b1, 1'b0});
    chk("ori_d0_illegal", {d0_out_valid, d0_illegal, d0_reg_write, d0_wr_reg}, {1'b1, 1'b1, 1'b0, 5'd0});
    in_instr = 32'h14220003;
    tick();
    chk("bne_ctrl", {branch, branch_ne, reg_write, illegal}, 4'b1100);
    chk("bne_alu", {alu_op, wr_reg}, {3'd1, 5'd0});
    chk("bne_imm", imm, 3);
    chk("bne_d0_illegal", {d0_out_valid, d0_illegal}, 2'b11);
    chk("bne_d0_ctrl", {d0_branch, d0_branch_ne, d0_alu_src, d0_reg_write, d0_jmp, d0_alu_op}, 8'd0);
    ex_mem_read = 1;
    ex_wr_reg = 2;
    tick();
    tick();
    chk("sat_d0_reach", d0_stall_cnt, 3);
    tick();
    tick();
    chk("sat_d0_hold", d0_stall_cnt, 3);
    chk("sat_d1_count", stall_cnt, 5);
    chk("sat_bubble", out_valid, 0);
    ex_wr_reg = 0;
    in_instr = 32'h00001820;
    #1;
    chk("r0_no_hazard", in_ready, 1);
    tick();
    chk("r0_issue", {out_valid, wr_reg}, {1'b1, 5'd3});
    chk("r0_stall_same", stall_cnt, 5);
    ex_mem_read = 0;
    in_instr = 32'h03E00008;
    tick();
    chk("jr_ctrl", {jr, jmp, reg_write, wr_reg}, {3'b110, 5'd0});
    chk("jr_d0_illegal", {d0_illegal, d0_jr, d0_jmp}, 3'b100);
    in_valid = 0;
    tick();
    chk("idle_valid", out_valid, 0);
    in_valid = 1;
    in_instr = 32'h00221820;
    tick();
    out_ready = 0;
    ex_mem_read = 1;
    ex_wr_reg = 1;
    rst = 1;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    tick();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_stall", stall_cnt, 0);
    chk("rst_mid_fields", {wr_reg, reg_write, rs}, 11'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_decoder.md
Name: pipe_decoder

Overview:
- Registered instruction-decode stage; successor to the combinational decoder.
- Sits between the fetch register and the execute stage; exchanges valid/ready on both sides.
- Decodes an extended opcode set and resolves the destination register.
- Generates sign/zero-extended immediates and jump targets.
- Detects load-use hazards against the execute stage, inserts bubbles, counts stalls.

Parameters:
- DATA_W, 32, instruction/PC/immediate width (≥32).
- REG_AW, 5, register address width.
- EXT_ISA, 1, 0 = base set only (add, sub, j, jal, beq, addi, lw, sw); 1 = also and, or, slt, jr, bne, andi, ori, slti.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch holds instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  DATA_W  instruction word
- in_pc  in  DATA_W  PC+4 of instruction
- flush  in  1  discard stage contents (branch taken)
- ex_mem_read  in  1  execute-stage instruction is a load
- ex_wr_reg  in  REG_AW  execute-stage destination
- out_ready  in  1  execute accepts
- out_valid  out  1  decoded bundle valid
- out_rs, out_rt, out_wr_reg  out  REG_AW  source regs; resolved destination
- out_imm  out  DATA_W  extended immediate
- out_jtarget  out  DATA_W  {pc[31:28], instr[25:0], 2'b00}
- out_pc  out  DATA_W  passthrough
- out_alu_src, out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write, out_branch, out_branch_ne, out_jmp, out_jr, out_pc_to_ra  out  1 each  controls
- out_alu_op  out  3  shared ALU_OP_* encoding (ADD, SUB, OR, SLT, AND)
- out_illegal  out  1  undecodable instruction
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (sync): out_valid=0; every out_* field 0; stall_cnt=0. Reset mid-stall drops the held instruction; in_ready is still computed combinationally during reset.
- adv = !out_valid || out_ready.
- hazard = in_valid && ex_mem_read && ex_wr_reg!=0 && (ex_wr_reg==rs || (uses_rt && ex_wr_reg==rt)).
  - uses_rt is 1 for R-type, beq, bne, sw.
- in_ready = adv && !hazard && !flush.
- Per cycle, priority order:
  - flush: out_valid<=0; input not consumed.
  - adv && hazard: load bubble (out_valid<=0, fields 0); stall_cnt+1, saturating at all-ones.
  - adv && in_valid: register decoded bundle; out_valid<=1. Latency 1 cycle.
  - adv && !in_valid: out_valid<=0.
  - !adv: hold every output unchanged.
- Decoding:
  - R-type (op 0):
    - func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
    - reg_write=1; wr_reg=rd.
    - func 001000 jr: jr=1, jmp=1, reg_write=0.
  - j (000010): jmp=1.
  - jal (000011): jmp=1, reg_write=1, pc_to_ra=1, wr_reg=31.
  - beq (000100) / bne (000101): branch=1, alu_op=SUB; bne sets branch_ne.
  - addi (001000) / slti (001010): sign-extended imm, alu_src=1, reg_write=1, wr_reg=rt.
  - andi (001100) / ori (001101): zero-extended imm, alu_src=1, reg_write=1, wr_reg=rt.
  - lw (100011): alu_src, mem_read, mem_to_reg, reg_write; wr_reg=rt.
  - sw (101011): alu_src, mem_write.
  - Address ops (lw, sw, addi) and branch offsets use the sign-extended imm.
- With EXT_ISA=0, extended encodings decode as illegal.
- Illegal encoding: all controls 0, out_illegal=1, out_valid=1 (execute raises the exception).
- wr_reg forced to 0 whenever reg_write=0.
- Outputs change only on clk edge.

Test Plan:
- Reset held 2 cycles with in_valid=1 -> out_valid=0, stall_cnt=0, all fields 0; first post-reset add $3,$1,$2 (0x00221820) -> next cycle out_valid=1, out_wr_reg=3, reg_write=1, alu_op=ADD.
- lw $5,-4($1) (0x8C25FFFC) -> out_imm=0xFFFFFFFC, wr_reg=5, mem_read=mem_to_reg=alu_src=1. Then ex_mem_read=1, ex_wr_reg=5 with add $6,$5,$2 -> in_ready=0 for 1 cycle, bubble, stall_cnt=1; ex_mem_read drops -> add issues.
- out_ready=0 for 3 cycles with a valid bundle -> outputs stable, in_ready=0; release -> next instruction registered.
- flush=1 with in_valid=1 -> out_valid=0 next cycle, in_ready=0, fetch instruction not consumed.
- jal 0x0100 at pc 0x40000004 -> wr_reg=31, pc_to_ra=1, jtarget=0x40000400; ori $2,$0,0x8000 -> out_imm=0x00008000.
- EXT_ISA=0 with bne (0x14220003) -> out_illegal=1, all controls 0; EXT_ISA=1 -> branch=branch_ne=1. Forced stall_cnt at max plus another stall -> count holds at max.
